bc_arbiter: RTL and testbench

BC_ARBITER -- requirements
Module: bc_arbiter

---
 rtl/bc_pkg.sv | 55 +++++
 rtl/bc_rr_arbiter.sv | 51 +++++
 rtl/bc_arbiter.sv | 124 ++++++++++++
 tb/tb_bc_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// bc_pkg: shared definitions for the bc_arbiter datapath sequencer.
// Holds the state encoding, the control-word layout and the per-state
// control-word constants, plus the Moore decode from state to control word.
package bc_pkg;

  // Eight states fit a 3-bit register exactly.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    S6   = 3'd6,
    FIN  = 3'd7
  } state_t;

  // Control word, MSB first in the order {M0,LX,M1,M2,LS,LH,H}.
  typedef struct packed {
    logic [1:0] m0;
    logic       lx;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       ls;
    logic       lh;
    logic       h;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CW_OFF = '0;
  localparam ctrl_t CW_S1  = '{m0: 2'd0, lx: 1'b1, m1: 2'd0, m2: 2'd0, ls: 1'b0, lh: 1'b0, h: 1'b0};
  localparam ctrl_t CW_S2  = '{m0: 2'd0, lx: 1'b0, m1: 2'd1, m2: 2'd0, ls: 1'b0, lh: 1'b1, h: 1'b1};
  localparam ctrl_t CW_S3  = '{m0: 2'd1, lx: 1'b0, m1: 2'd0, m2: 2'd3, ls: 1'b1, lh: 1'b0, h: 1'b1};
  localparam ctrl_t CW_S4  = '{m0: 2'd2, lx: 1'b0, m1: 2'd0, m2: 2'd0, ls: 1'b0, lh: 1'b1, h: 1'b1};
  localparam ctrl_t CW_S5  = '{m0: 2'd0, lx: 1'b0, m1: 2'd2, m2: 2'd3, ls: 1'b1, lh: 1'b0, h: 1'b0};
  localparam ctrl_t CW_S6  = '{m0: 2'd3, lx: 1'b0, m1: 2'd0, m2: 2'd2, ls: 1'b1, lh: 1'b0, h: 1'b0};

  // Moore decode: the control word depends on the current state only.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t cw;
    cw = CW_OFF;
    case (s)
      S1:      cw = CW_S1;
      S2:      cw = CW_S2;
      S3:      cw = CW_S3;
      S4:      cw = CW_S4;
      S5:      cw = CW_S5;
      S6:      cw = CW_S6;
      default: cw = CW_OFF;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/bc_rr_arbiter.sv
// bc_rr_arbiter: combinational winner selection for bc_arbiter.
// Default build: round-robin, search starts at last+1 (mod N_REQ).
// With BC_ARB_FIXED_PRIORITY_EN defined: lowest index wins and there is
// no last input.
module bc_rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
`ifndef BC_ARB_FIXED_PRIORITY_EN
  input  logic [IDX_W-1:0] last,
`endif
  output logic [N_REQ-1:0] winner
);

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [N_REQ-1:0] lowest(input logic [N_REQ-1:0] v);
    return v & (~v + N_REQ'(1));
  endfunction

`ifdef BC_ARB_FIXED_PRIORITY_EN

  // Fixed priority: the lowest requesting index always wins.
  always_comb begin
    winner = lowest(req);
  end

`else

  // Requesters strictly above the last winner get first pick; if none of
  // them is requesting, the search wraps to the lowest requesting index.
  logic [N_REQ-1:0] upper_mask;
  logic [N_REQ-1:0] upper_req;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign upper_mask[gi] = (IDX_W'(gi) > last);
  end

  // Pick the first request after last, otherwise wrap around.
  always_comb begin
    upper_req = req & upper_mask;
    if (|upper_req) begin
      winner = lowest(upper_req);
    end else begin
      winner = lowest(req);
    end
  end

`endif

endmodule

// File: rtl/bc_arbiter.sv
// bc_arbiter: N_REQ requesters share one datapath. A granted operation runs
// S1..S6 then FIN (7 busy cycles); the control word is a Moore decode of the
// state. Requests are only sampled in IDLE.
// Build option: BC_ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority
// instead of round-robin (no last-winner pointer is kept in that case).
module bc_arbiter
  import bc_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic             LX,
  output logic             LS,
  output logic             LH,
  output logic             H,
  output logic [1:0]       M0,
  output logic [1:0]       M1,
  output logic [1:0]       M2
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state;
  state_t           state_next;
  ctrl_t            ctrl;
  logic [N_REQ-1:0] winner;
  logic             start;

  // A new operation starts when any request is seen while idle.
  assign start = (state == IDLE) && (|req);

`ifdef BC_ARB_FIXED_PRIORITY_EN

  bc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .winner (winner)
  );

`else

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] winner_idx;

  bc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .last   (last),
    .winner (winner)
  );

  // Encode the one-hot winner back to an index for the pointer.
  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) winner_idx = IDX_W'(i);
    end
  end

  // Remember the most recent winner; reset value makes requester 0 win first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= IDX_W'(N_REQ - 1);
    end else if (start) begin
      last <= winner_idx;
    end
  end

`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant is captured at the start edge and held until the return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt <= '0;
    end else if (start) begin
      gnt <= winner;
    end else if (state == FIN) begin
      gnt <= '0;
    end
  end

  // Next state and Moore outputs decoded from the current state.
  always_comb begin
    state_next = state;
    ctrl       = ctrl_decode(state);
    done       = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = S1;
      S1:      state_next = S2;
      S2:      state_next = S3;
      S3:      state_next = S4;
      S4:      state_next = S5;
      S5:      state_next = S6;
      S6:      state_next = FIN;
      FIN: begin
        state_next = IDLE;
        done       = gnt;
      end
      default: state_next = IDLE;
    endcase
  end

  assign M0 = ctrl.m0;
  assign LX = ctrl.lx;
  assign M1 = ctrl.m1;
  assign M2 = ctrl.m2;
  assign LS = ctrl.ls;
  assign LH = ctrl.lh;
  assign H  = ctrl.h;

endmodule

// File: tb/tb_bc_arbiter.sv
// tb_bc_arbiter: table-driven vectors, directed multi-cycle sequences and
// randomized requests checked against an operation-level reference model.
module tb_bc_arbiter;

  localparam int N  = 2;
  localparam int OW = 2 * N + 11;

  typedef logic [OW-1:0] obs_t;

  typedef struct {
    logic [N-1:0] req;
    obs_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         busy;
  logic         LX, LS, LH, H;
  logic [1:0]   M0, M1, M2;

  int checks = 0;
  int errors = 0;

  // Reference model: operation phase 0 = idle, 1..6 = steps, 7 = finish.
  int m_phase;
  int m_win;
  int m_last;

  vec_t vecs[$];

  bc_arbiter #(.N_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .LX    (LX),
    .LS    (LS),
    .LH    (LH),
    .H     (H),
    .M0    (M0),
    .M1    (M1),
    .M2    (M2)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no $finish, want completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  // Control word {M0,LX,M1,M2,LS,LH,H} for each operation phase.
  function automatic logic [9:0] cw_of(input int p);
    case (p)
      1:       return {2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      2:       return {2'd0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1};
      3:       return {2'd1, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1};
      4:       return {2'd2, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1};
      5:       return {2'd0, 1'b0, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0};
      6:       return {2'd3, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0};
      default: return 10'd0;
    endcase
  endfunction

  function automatic obs_t mk(input logic [N-1:0] g, input logic [N-1:0] d,
                              input logic b, input logic [9:0] cw);
    return {g, d, b, cw};
  endfunction

  function automatic obs_t dut_obs();
    return {gnt, done, busy, M0, LX, M1, M2, LS, LH, H};
  endfunction

  function automatic obs_t model_obs();
    logic [N-1:0] g;
    logic [N-1:0] d;
    g = (m_phase != 0) ? N'(1 << m_win) : '0;
    d = (m_phase == 7) ? g : '0;
    return mk(g, d, m_phase != 0, cw_of(m_phase));
  endfunction

  // Advance the model by one clock edge with request vector r.
  task automatic model_edge(input logic [N-1:0] r);
    if (m_phase == 0) begin
      if (r != '0) begin
`ifdef BC_ARB_FIXED_PRIORITY_EN
        for (int k = N - 1; k >= 0; k--) begin
          if ((r & N'(1 << k)) != '0) m_win = k;
        end
`else
        for (int k = N; k >= 1; k--) begin
          if ((r & N'(1 << ((m_last + k) % N))) != '0) m_win = (m_last + k) % N;
        end
        m_last = m_win;
`endif
        m_phase = 1;
      end
    end else begin
      m_phase = (m_phase == 7) ? 0 : m_phase + 1;
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {gnt,done,busy,cw}=%b want %b", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock edge: drive req, let the edge happen, sample 1 time unit later.
  task automatic edge_only(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    $display("t=%0t req=%b gnt=%b done=%b busy=%b cw=%b", $time, r, gnt, done, busy,
             {M0, LX, M1, M2, LS, LH, H});
  endtask

  task automatic step(input logic [N-1:0] r, input string name);
    edge_only(r);
    check_obs(name, dut_obs(), model_obs());
  endtask

  // Assert reset mid-cycle, check outputs clear at once and over an edge.
  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    m_phase = 0;
    m_win   = 0;
    m_last  = N - 1;
    check_obs({name, " immediate"}, dut_obs(), '0);
    @(posedge clk);
    #1;
    check_obs({name, " held"}, dut_obs(), '0);
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic [N-1:0] r, input obs_t e);
    vec_t v;
    v.req = r;
    v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [N-1:0] exp_gnt [3];
    logic [N-1:0] r;

`ifdef BC_ARB_FIXED_PRIORITY_EN
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01;
`else
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
`endif

    // Single request pulsed at edge 0: explicit expected outputs per edge.
    add_vec(2'b01, mk(2'b01, 2'b00, 1'b1, cw_of(1)));
    add_vec(2'b00, mk(2'b01, 2'b00, 1'b1, cw_of(2)));
    add_vec(2'b00, mk(2'b01, 2'b00, 1'b1, cw_of(3)));
    add_vec(2'b00, mk(2'b01, 2'b00, 1'b1, cw_of(4)));
    add_vec(2'b00, mk(2'b01, 2'b00, 1'b1, cw_of(5)));
    add_vec(2'b00, mk(2'b01, 2'b00, 1'b1, cw_of(6)));
    add_vec(2'b00, mk(2'b01, 2'b01, 1'b1, 10'd0));
    add_vec(2'b00, mk(2'b00, 2'b00, 1'b0, 10'd0));
    add_vec(2'b00, mk(2'b00, 2'b00, 1'b0, 10'd0));

    reset = 1'b1;
    req   = '0;
    m_phase = 0;
    m_win   = 0;
    m_last  = N - 1;
    @(posedge clk);
    #1;
    do_reset("reset");

    foreach (vecs[i]) begin
      edge_only(vecs[i].req);
      check_obs($sformatf("single edge%0d", i), dut_obs(), vecs[i].exp);
    end

    // Contention: both requesters held from reset release.
    do_reset("contention reset");
    for (int e = 0; e < 24; e++) begin
      step(2'b11, $sformatf("contention edge%0d", e));
      if (e == 0)  check_v("contention grant0", 32'(gnt), 32'(exp_gnt[0]));
      if (e == 7)  check_v("contention idle gap0", 32'(busy), 32'd0);
      if (e == 8)  check_v("contention grant1", 32'(gnt), 32'(exp_gnt[1]));
      if (e == 15) check_v("contention idle gap1", 32'(busy), 32'd0);
      if (e == 16) check_v("contention grant2", 32'(gnt), 32'(exp_gnt[2]));
    end

    // Withdrawal: req0 drops once the operation is in S3.
    do_reset("withdraw reset");
    for (int e = 0; e < 9; e++) begin
      step((e < 3) ? 2'b01 : 2'b00, $sformatf("withdraw edge%0d", e));
      if (e == 6) check_v("withdraw done", 32'(done), 32'h1);
    end

    // Late arrival: req1 rises during S4 and waits for IDLE.
    do_reset("late reset");
    for (int e = 0; e < 10; e++) begin
      step((e == 0) ? 2'b01 : ((e >= 4) ? 2'b10 : 2'b00), $sformatf("late edge%0d", e));
      if (e == 6) check_v("late still gnt0", 32'(gnt), 32'h1);
      if (e == 7) check_v("late idle", 32'(gnt), 32'h0);
      if (e == 8) check_v("late grant", 32'(gnt), 32'h2);
    end

    // Reset during S5, then a full operation with req0 held.
    do_reset("midop pre reset");
    for (int e = 0; e < 5; e++) step((e == 0) ? 2'b01 : 2'b00, $sformatf("midop edge%0d", e));
    check_v("midop in S5 cw", 32'({M0, LX, M1, M2, LS, LH, H}), 32'(cw_of(5)));
    do_reset("midop reset");
    for (int e = 0; e < 9; e++) begin
      step(2'b01, $sformatf("midop restart edge%0d", e));
      if (e == 6) check_v("midop restart done", 32'(done), 32'h1);
    end

    // Randomized requests with occasional resets.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset($sformatf("random reset %0d", t));
      end else begin
        r = N'($urandom);
        step(r, $sformatf("random %0d", t));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
